// File: rtl/dmem_access_ctrl.sv
// Data-memory access sequencer: drives one access at a time onto a variable-latency
// bus, generates big-endian lane selects, aligns/extends load data, reports misalignment/timeout.
module dmem_access_ctrl #(
  parameter int unsigned TIMEOUT_CYC = 32'd255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush_i,
  input  logic        req_valid_i,
  input  logic        req_we_i,
  input  logic [1:0]  req_size_i,
  input  logic        req_sext_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        stallreq_o,
  output logic        done_o,
  output logic        err_o,
  output logic [31:0] rdata_o,
  output logic        bus_cyc_o,
  output logic        bus_stb_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [3:0]  bus_sel_o,
  output logic [31:0] bus_wdata_o,
  input  logic [31:0] bus_rdata_i,
  input  logic        bus_ack_i
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_BUSY = 2'b01,
    S_DONE = 2'b10
  } state_t;

  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYC - 32'd1);

  // Picks the addressed lanes out of a big-endian bus word and extends them.
  function automatic logic [31:0] f_align_load(input logic [31:0] rd, input logic [1:0] sz,
                                               input logic [1:0] lo, input logic sx);
    logic [7:0]  v_b;
    logic [15:0] v_h;
    logic [31:0] v_res;
    v_b   = 8'h00;
    v_h   = 16'h0000;
    v_res = rd;
    case (lo)
      2'b00:   v_b = rd[31:24];
      2'b01:   v_b = rd[23:16];
      2'b10:   v_b = rd[15:8];
      default: v_b = rd[7:0];
    endcase
    if (lo[1]) begin
      v_h = rd[15:0];
    end else begin
      v_h = rd[31:16];
    end
    case (sz)
      2'b00:   v_res = {{24{sx & v_b[7]}}, v_b};
      2'b01:   v_res = {{16{sx & v_h[15]}}, v_h};
      default: v_res = rd;
    endcase
    return v_res;
  endfunction

  state_t      r_state, w_state_nxt;
  logic        r_we, w_we_nxt;
  logic [3:0]  r_sel, w_sel_nxt;
  logic [31:0] r_addr, w_addr_nxt;
  logic [31:0] r_wdata, w_wdata_nxt;
  logic [1:0]  r_size, w_size_nxt;
  logic [1:0]  r_lo, w_lo_nxt;
  logic        r_sext, w_sext_nxt;
  logic        r_cyc, w_cyc_nxt;
  logic [15:0] r_cnt, w_cnt_nxt;
  logic        r_flush, w_flush_nxt;
  logic [31:0] r_rdata, w_rdata_nxt;
  logic        r_err, w_err_nxt;
  logic        w_stall;
  logic        w_aligned;
  logic [3:0]  w_sel;
  logic [31:0] w_wdata;
  logic        w_flushed;

  // Request decode: lane selects, replicated store data, alignment.
  always_comb begin
    w_sel     = 4'b1111;
    w_wdata   = req_wdata_i;
    w_aligned = 1'b1;
    case (req_size_i)
      2'b00: begin
        w_sel     = 4'b1000 >> req_addr_i[1:0];
        w_wdata   = {4{req_wdata_i[7:0]}};
        w_aligned = 1'b1;
      end
      2'b01: begin
        w_sel     = req_addr_i[1] ? 4'b0011 : 4'b1100;
        w_wdata   = {2{req_wdata_i[15:0]}};
        w_aligned = ~req_addr_i[0];
      end
      default: begin
        w_sel     = 4'b1111;
        w_wdata   = req_wdata_i;
        w_aligned = (req_addr_i[1:0] == 2'b00);
      end
    endcase
  end

  assign w_flushed = r_flush | flush_i;

  // Next-state and next-register values for the access FSM.
  always_comb begin
    w_state_nxt = r_state;
    w_we_nxt    = r_we;
    w_sel_nxt   = r_sel;
    w_addr_nxt  = r_addr;
    w_wdata_nxt = r_wdata;
    w_size_nxt  = r_size;
    w_lo_nxt    = r_lo;
    w_sext_nxt  = r_sext;
    w_cyc_nxt   = r_cyc;
    w_cnt_nxt   = r_cnt;
    w_flush_nxt = r_flush;
    w_rdata_nxt = r_rdata;
    w_err_nxt   = r_err;
    w_stall     = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_stall     = req_valid_i & ~flush_i;
        w_flush_nxt = 1'b0;
        if (req_valid_i && !flush_i) begin
          if (w_aligned) begin
            w_we_nxt    = req_we_i;
            w_sel_nxt   = w_sel;
            w_addr_nxt  = {req_addr_i[31:2], 2'b00};
            w_wdata_nxt = w_wdata;
            w_size_nxt  = req_size_i;
            w_lo_nxt    = req_addr_i[1:0];
            w_sext_nxt  = req_sext_i;
            w_cnt_nxt   = 16'h0000;
            w_cyc_nxt   = 1'b1;
            w_state_nxt = S_BUSY;
          end else begin
            w_err_nxt   = 1'b1;
            w_rdata_nxt = 32'h0000_0000;
            w_state_nxt = S_DONE;
          end
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_BUSY: begin
        w_stall     = 1'b1;
        w_flush_nxt = w_flushed;
        if (bus_ack_i || (r_cnt == CNT_LAST)) begin
          w_cyc_nxt = 1'b0;
          if (w_flushed) begin
            w_flush_nxt = 1'b0;
            w_state_nxt = S_IDLE;
          end else begin
            w_state_nxt = S_DONE;
          end
          // Ack outranks a coincident timeout.
          if (bus_ack_i) begin
            w_err_nxt   = 1'b0;
            w_rdata_nxt = r_we ? 32'h0000_0000 : f_align_load(bus_rdata_i, r_size, r_lo, r_sext);
          end else begin
            w_err_nxt   = 1'b1;
            w_rdata_nxt = 32'h0000_0000;
          end
        end else begin
          w_cnt_nxt = r_cnt + 16'h0001;
        end
      end
      S_DONE: begin
        w_flush_nxt = 1'b0;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_cyc_nxt   = 1'b0;
        w_flush_nxt = 1'b0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_we    <= 1'b0;
      r_sel   <= 4'h0;
      r_addr  <= 32'h0000_0000;
      r_wdata <= 32'h0000_0000;
      r_size  <= 2'b00;
      r_lo    <= 2'b00;
      r_sext  <= 1'b0;
      r_cyc   <= 1'b0;
      r_cnt   <= 16'h0000;
      r_flush <= 1'b0;
      r_rdata <= 32'h0000_0000;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_we    <= w_we_nxt;
      r_sel   <= w_sel_nxt;
      r_addr  <= w_addr_nxt;
      r_wdata <= w_wdata_nxt;
      r_size  <= w_size_nxt;
      r_lo    <= w_lo_nxt;
      r_sext  <= w_sext_nxt;
      r_cyc   <= w_cyc_nxt;
      r_cnt   <= w_cnt_nxt;
      r_flush <= w_flush_nxt;
      r_rdata <= w_rdata_nxt;
      r_err   <= w_err_nxt;
    end
  end

  assign stallreq_o  = w_stall;
  assign done_o      = (r_state == S_DONE);
  assign err_o       = r_err;
  assign rdata_o     = r_rdata;
  assign bus_cyc_o   = r_cyc;
  assign bus_stb_o   = r_cyc;
  assign bus_we_o    = r_we;
  assign bus_addr_o  = r_addr;
  assign bus_sel_o   = r_sel;
  assign bus_wdata_o = r_wdata;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Self-checking bench for dmem_access_ctrl: directed test-plan accesses plus randomized
// accesses checked against a byte-lane arithmetic model of the bus protocol.
module tb_dmem_access_ctrl;

  localparam int T = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush_i = 1'b0;
  logic        req_valid_i = 1'b0;
  logic        req_we_i = 1'b0;
  logic [1:0]  req_size_i = 2'b00;
  logic        req_sext_i = 1'b0;
  logic [31:0] req_addr_i = 32'h0;
  logic [31:0] req_wdata_i = 32'h0;
  logic        stallreq_o, done_o, err_o;
  logic [31:0] rdata_o;
  logic        bus_cyc_o, bus_stb_o, bus_we_o;
  logic [31:0] bus_addr_o, bus_wdata_o;
  logic [3:0]  bus_sel_o;
  logic [31:0] bus_rdata_i = 32'h0;
  logic        bus_ack_i = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  dmem_access_ctrl #(.TIMEOUT_CYC(T)) dut (
    .clk(clk), .rst(rst), .flush_i(flush_i),
    .req_valid_i(req_valid_i), .req_we_i(req_we_i), .req_size_i(req_size_i),
    .req_sext_i(req_sext_i), .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
    .stallreq_o(stallreq_o), .done_o(done_o), .err_o(err_o), .rdata_o(rdata_o),
    .bus_cyc_o(bus_cyc_o), .bus_stb_o(bus_stb_o), .bus_we_o(bus_we_o),
    .bus_addr_o(bus_addr_o), .bus_sel_o(bus_sel_o), .bus_wdata_o(bus_wdata_o),
    .bus_rdata_i(bus_rdata_i), .bus_ack_i(bus_ack_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int nbytes(input logic [1:0] sz);
    if (sz == 2'd0) return 1;
    else if (sz == 2'd1) return 2;
    else return 4;
  endfunction

  function automatic logic [31:0] exp_load(input logic [1:0] sz, input logic sx,
                                           input logic [31:0] ad, input logic [31:0] rd);
    int nb;
    int off;
    logic [31:0] v;
    nb  = nbytes(sz);
    off = int'(ad[1:0]);
    if (nb == 4) return rd;
    v = rd >> (8 * (4 - nb - off));
    v = v & ((32'd1 << (8 * nb)) - 32'd1);
    if (sx && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8 * nb));
    return v;
  endfunction

  function automatic logic [31:0] exp_sel(input logic [1:0] sz, input logic [31:0] ad);
    int nb;
    nb = nbytes(sz);
    return ((32'd1 << nb) - 32'd1) << (4 - nb - int'(ad[1:0]));
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [1:0] sz, input logic [31:0] wd);
    int nb;
    nb = nbytes(sz);
    if (nb == 1) return {24'h0, wd[7:0]} * 32'h0101_0101;
    else if (nb == 2) return {16'h0, wd[15:0]} * 32'h0001_0001;
    else return wd;
  endfunction

  // ack_wait: BUSY cycles without ack before the ack (>= T means never);
  // flush_cyc: BUSY cycle index carrying a flush pulse (-1 for none).
  task automatic run_access(input logic we, input logic [1:0] sz, input logic sx,
                            input logic [31:0] ad, input logic [31:0] wd,
                            input int ack_wait, input logic [31:0] brd, input int flush_cyc);
    int nb;
    int last;
    logic ali, tmo, flushed;
    nb  = nbytes(sz);
    ali = (int'(ad[1:0]) % nb) == 0;
    @(negedge clk);
    req_valid_i = 1'b1; req_we_i = we; req_size_i = sz; req_sext_i = sx;
    req_addr_i = ad; req_wdata_i = wd; flush_i = 1'b0; bus_ack_i = 1'b0;
    #1;
    chk("req_stall", stallreq_o, 1);
    chk("req_cyc", bus_cyc_o, 0);
    @(posedge clk);
    @(negedge clk);
    if (!ali) begin
      req_valid_i = 1'b0;
      #1;
      chk("mis_done", done_o, 1);
      chk("mis_err", err_o, 1);
      chk("mis_rdata", rdata_o, 0);
      chk("mis_cyc", bus_cyc_o, 0);
      chk("mis_stall", stallreq_o, 0);
    end else begin
      tmo     = (ack_wait >= T);
      last    = tmo ? T - 1 : ack_wait;
      flushed = (flush_cyc >= 0) && (flush_cyc <= last);
      for (int k = 0; k <= last; k++) begin
        if (k > 0) @(negedge clk);
        chk("busy_cyc", bus_cyc_o, 1);
        chk("busy_stb", bus_stb_o, 1);
        chk("busy_we", bus_we_o, we);
        chk("busy_addr", bus_addr_o, ad & 32'hFFFF_FFFC);
        chk("busy_sel", bus_sel_o, exp_sel(sz, ad));
        chk("busy_wdata", bus_wdata_o, exp_wdata(sz, wd));
        chk("busy_stall", stallreq_o, 1);
        chk("busy_done", done_o, 0);
        bus_ack_i   = (k == ack_wait);
        bus_rdata_i = (k == ack_wait) ? brd : $urandom();
        flush_i     = (k == flush_cyc);
        @(posedge clk);
      end
      @(negedge clk);
      bus_ack_i = 1'b0; flush_i = 1'b0; req_valid_i = 1'b0;
      #1;
      chk("end_cyc", bus_cyc_o, 0);
      if (flushed) begin
        chk("flush_nodone", done_o, 0);
        chk("flush_stall", stallreq_o, 0);
      end else begin
        chk("end_done", done_o, 1);
        chk("end_stall", stallreq_o, 0);
        chk("end_err", err_o, tmo);
        chk("end_rdata", rdata_o, (tmo || we) ? 32'h0 : exp_load(sz, sx, ad, brd));
      end
    end
    @(posedge clk);
    @(negedge clk);
    chk("after_done", done_o, 0);
  endtask

  initial begin
    logic [31:0] ad;
    // Power-on reset
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_cyc", bus_cyc_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_stall", stallreq_o, 0);
    chk("rst_rdata", rdata_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_sel", bus_sel_o, 0);
    rst = 1'b1;

    // Directed test-plan accesses
    run_access(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 0, 32'h1234_5678, -1);
    run_access(1'b0, 2'b00, 1'b1, 32'h103, 32'h0, 3, 32'h0000_00F0, -1);
    run_access(1'b0, 2'b00, 1'b0, 32'h103, 32'h0, 3, 32'h0000_00F0, -1);
    run_access(1'b1, 2'b01, 1'b0, 32'h202, 32'h0000_ABCD, 1, 32'hDEAD_BEEF, -1);
    run_access(1'b0, 2'b10, 1'b0, 32'h101, 32'h0, 0, 32'h0, -1);
    run_access(1'b0, 2'b10, 1'b0, 32'h300, 32'h0, T, 32'h0, -1);
    run_access(1'b0, 2'b01, 1'b1, 32'h402, 32'h0, 2, 32'h0000_8001, 0);
    run_access(1'b0, 2'b11, 1'b0, 32'h500, 32'h0, 1, 32'hCAFE_F00D, -1);

    // Flush in IDLE suppresses the start; ack in IDLE is ignored
    @(negedge clk);
    req_valid_i = 1'b1; req_we_i = 1'b0; req_size_i = 2'b10; req_addr_i = 32'h600;
    flush_i = 1'b1;
    #1;
    chk("idle_flush_stall", stallreq_o, 0);
    @(posedge clk);
    @(negedge clk);
    req_valid_i = 1'b0; flush_i = 1'b0; bus_ack_i = 1'b1;
    #1;
    chk("idle_flush_cyc", bus_cyc_o, 0);
    chk("idle_flush_done", done_o, 0);
    @(posedge clk);
    @(negedge clk);
    bus_ack_i = 1'b0;
    chk("idle_ack_done", done_o, 0);
    chk("idle_ack_cyc", bus_cyc_o, 0);

    // Randomized accesses
    for (int i = 0; i < 60; i++) begin
      ad = $urandom();
      if ($urandom_range(0, 1) == 0) ad[1:0] = 2'b00;
      run_access(1'(($urandom() % 2)), 2'($urandom() % 4), 1'($urandom() % 2), ad,
                 $urandom(), int'($urandom_range(0, T)), $urandom(),
                 (($urandom() % 4) == 0) ? int'($urandom_range(0, T - 1)) : -1);
    end

    // Leave err_o set, then reset in the middle of a store
    run_access(1'b0, 2'b10, 1'b0, 32'h702, 32'h0, 0, 32'h0, -1);
    @(negedge clk);
    req_valid_i = 1'b1; req_we_i = 1'b1; req_size_i = 2'b10; req_addr_i = 32'h800;
    req_wdata_i = 32'h5A5A_A5A5;
    @(posedge clk);
    @(negedge clk);
    chk("mid_cyc_before", bus_cyc_o, 1);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    req_valid_i = 1'b0;
    #1;
    chk("mid_rst_cyc", bus_cyc_o, 0);
    chk("mid_rst_stb", bus_stb_o, 0);
    chk("mid_rst_we", bus_we_o, 0);
    chk("mid_rst_addr", bus_addr_o, 0);
    chk("mid_rst_sel", bus_sel_o, 0);
    chk("mid_rst_wdata", bus_wdata_o, 0);
    chk("mid_rst_done", done_o, 0);
    chk("mid_rst_err", err_o, 0);
    chk("mid_rst_rdata", rdata_o, 0);
    chk("mid_rst_stall", stallreq_o, 0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("post_rst_done", done_o, 0);
    run_access(1'b0, 2'b00, 1'b1, 32'h901, 32'h0, 0, 32'h0080_0000, -1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
